disp_scan_ctrl: RTL

Scan scheduler for the 6-digit multiplexed 7-segment display. Holds a tear-free double-buffered digit image written by upstream logic over a req/ack port. Time-multiplexes the digits with per-digit dead-time blanking and 8-level PWM brightness. Drives the segment bus and the digit-select bus directly, replacing the free-running row/column scanners.

---
 rtl/disp_scan_ctrl_if.sv | 30 +++
 rtl/disp_scan_ctrl.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/disp_scan_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : disp_scan_ctrl_if
// Description : Digit-image write port for disp_scan_ctrl. The request is held
//               until the one-cycle acknowledge returns.
// Revision    : 1.0 - initial release
// ============================================================================
interface disp_scan_ctrl_if;
  logic       wr_req;
  logic [2:0] wr_addr;
  logic [7:0] wr_data;
  logic       wr_ack;

  // Upstream writer
  modport master (
    output wr_req,
    output wr_addr,
    output wr_data,
    input  wr_ack
  );

  // Scan controller
  modport slave (
    input  wr_req,
    input  wr_addr,
    input  wr_data,
    output wr_ack
  );
endinterface
`default_nettype wire

// File: rtl/disp_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : disp_scan_ctrl
// Description : Scan scheduler for a 6-digit multiplexed 7-segment display.
//               Double-buffered digit image (shadow -> disp at frame start),
//               per-digit dead-time blanking and 8-level PWM brightness.
// Revision    : 1.0 - initial release
// ============================================================================
module disp_scan_ctrl #(
  parameter int SCAN_DIV  = 10000,  // clock cycles per digit slot
  parameter int BLANK_CYC = 200     // dead-time cycles at slot start (>= 1)
) (
  input  logic            CLK,
  input  logic            RST_n,
  input  logic            enable,
  input  logic [2:0]      bright,
  disp_scan_ctrl_if.slave wr_if,
  output logic [7:0]      Row_Scan_Sig,
  output logic [5:0]      Column_Scan_Sig,
  output logic            frame_done
);

  // Slot geometry; the active phase splits into 8 equal PWM subslots.
  localparam int c_act    = SCAN_DIV - BLANK_CYC;
  localparam int c_sub    = c_act / 8;
  localparam int c_slot_w = $clog2(SCAN_DIV);
  localparam int c_sub_w  = (c_sub > 1) ? $clog2(c_sub) : 1;

  localparam logic [c_slot_w-1:0] c_slot_last  = c_slot_w'(SCAN_DIV - 1);
  localparam logic [c_slot_w-1:0] c_slot_pre   = c_slot_w'(SCAN_DIV - 2);
  localparam logic [c_slot_w-1:0] c_blank_last = c_slot_w'(BLANK_CYC - 1);
  localparam logic [c_slot_w-1:0] c_act_first  = c_slot_w'(BLANK_CYC);
  localparam logic [c_sub_w-1:0]  c_sub_last   = c_sub_w'(c_sub - 1);
  localparam logic [2:0]          c_digit_last = 3'd5;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BLANK = 2'd1,
    ST_ON    = 2'd2,
    ST_OFF   = 2'd3
  } state_e;

  state_e                state_q,    state_d;
  logic [c_slot_w-1:0]   slot_cnt_q, slot_cnt_d;
  logic [c_sub_w-1:0]    sub_cnt_q,  sub_cnt_d;
  logic [2:0]            subslot_q,  subslot_d;
  logic [2:0]            digit_q,    digit_d;
  logic [2:0]            bright_q,   bright_d;
  logic [7:0]            shadow_q [6];
  logic [7:0]            shadow_d [6];
  logic [7:0]            disp_q   [6];
  logic [7:0]            disp_d   [6];
  logic [7:0]            row_q,      row_d;
  logic [5:0]            col_q,      col_d;
  logic                  ack_q,      ack_d;
  logic                  frame_done_q, frame_done_d;
  logic                  frame_copy;

  // Scan sequencing: slot/subslot/digit counters and next state.
  always_comb begin
    state_d      = state_q;
    slot_cnt_d   = slot_cnt_q;
    sub_cnt_d    = sub_cnt_q;
    subslot_d    = subslot_q;
    digit_d      = digit_q;
    bright_d     = bright_q;
    frame_done_d = 1'b0;
    frame_copy   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (enable) begin
          state_d    = ST_BLANK;
          slot_cnt_d = '0;
          digit_d    = 3'd0;
          bright_d   = bright;
          frame_copy = 1'b1;
        end
      end
      ST_BLANK: begin
        if (slot_cnt_q == c_blank_last) begin
          // Subslot 0 is always lit, whatever the brightness.
          state_d    = ST_ON;
          slot_cnt_d = c_act_first;
          sub_cnt_d  = '0;
          subslot_d  = 3'd0;
        end else begin
          slot_cnt_d = slot_cnt_q + c_slot_w'(1);
        end
      end
      ST_ON, ST_OFF: begin
        if (slot_cnt_q == c_slot_last) begin
          state_d    = ST_BLANK;
          slot_cnt_d = '0;
          bright_d   = bright;
          digit_d    = (digit_q == c_digit_last) ? 3'd0 : digit_q + 3'd1;
        end else begin
          slot_cnt_d = slot_cnt_q + c_slot_w'(1);
          if (sub_cnt_q == c_sub_last) begin
            sub_cnt_d = '0;
            subslot_d = subslot_q + 3'd1;
          end else begin
            sub_cnt_d = sub_cnt_q + c_sub_w'(1);
          end
          state_d = (subslot_d <= bright_q) ? ST_ON : ST_OFF;
          // Copy lands on the edge into the frame's last cycle, so a write
          // committing on that same edge still sees the old shadow copied.
          if ((slot_cnt_q == c_slot_pre) && (digit_q == c_digit_last)) begin
            frame_done_d = 1'b1;
            frame_copy   = 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Disable abandons the slot; re-enable restarts the frame at digit 0.
    if (!enable) begin
      state_d      = ST_IDLE;
      slot_cnt_d   = '0;
      digit_d      = 3'd0;
      frame_done_d = 1'b0;
      frame_copy   = 1'b0;
    end
  end

  // Write port handshake and double-buffer update.
  always_comb begin
    ack_d    = wr_if.wr_req & ~ack_q;
    shadow_d = shadow_q;
    disp_d   = disp_q;
    if (frame_copy) begin
      disp_d = shadow_q;
    end
    // Addresses 6..7 match no entry: acknowledged and dropped.
    for (int i = 0; i < 6; i++) begin
      if (ack_d && (wr_if.wr_addr == 3'(i))) begin
        shadow_d[i] = wr_if.wr_data;
      end
    end
  end

  // Output drive for the upcoming cycle, derived from the next state.
  always_comb begin
    row_d = 8'hFF;
    col_d = 6'h3F;
    if (state_d == ST_ON) begin
      for (int i = 0; i < 6; i++) begin
        if (digit_d == 3'(i)) begin
          row_d    = disp_q[i];
          col_d[i] = 1'b0;
        end
      end
    end
  end

  // State, counters, buffers and registered outputs.
  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      state_q      <= ST_IDLE;
      slot_cnt_q   <= '0;
      sub_cnt_q    <= '0;
      subslot_q    <= 3'd0;
      digit_q      <= 3'd0;
      bright_q     <= 3'd0;
      row_q        <= 8'hFF;
      col_q        <= 6'h3F;
      ack_q        <= 1'b0;
      frame_done_q <= 1'b0;
      for (int i = 0; i < 6; i++) begin
        shadow_q[i] <= 8'hFF;
        disp_q[i]   <= 8'hFF;
      end
    end else begin
      state_q      <= state_d;
      slot_cnt_q   <= slot_cnt_d;
      sub_cnt_q    <= sub_cnt_d;
      subslot_q    <= subslot_d;
      digit_q      <= digit_d;
      bright_q     <= bright_d;
      row_q        <= row_d;
      col_q        <= col_d;
      ack_q        <= ack_d;
      frame_done_q <= frame_done_d;
      for (int i = 0; i < 6; i++) begin
        shadow_q[i] <= shadow_d[i];
        disp_q[i]   <= disp_d[i];
      end
    end
  end

  assign Row_Scan_Sig    = row_q;
  assign Column_Scan_Sig = col_q;
  assign frame_done      = frame_done_q;
  assign wr_if.wr_ack    = ack_q;

endmodule
`default_nettype wire
